kbd_paddle_ctrl: RTL and testbench

- Sits directly downstream of the PS/2 keyboard core; consumes its decoded key stream (scancode, data_ready, released, err_ind) and returns the one-cycle read acknowledge.
- Tracks which game keys are held and converts them into two clamped paddle positions, updated at a fixed tick rate.
- Produces serve and pause controls for the pong game logic.

---
 rtl/kbd_codes_pkg.sv | 25 ++
 rtl/paddle_axis.sv | 48 ++++
 rtl/kbd_paddle_ctrl.sv | 147 ++++++++++++++
 tb/tb_kbd_paddle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_codes_pkg.sv
// Shared key-code constants and handshake state encodings for the keyboard path.
// The keyboard core's output mapping uses these same codes.
package kbd_codes_pkg;

    localparam logic [7:0] KEY_W     = 8'h77;
    localparam logic [7:0] KEY_S     = 8'h73;
    localparam logic [7:0] KEY_UP    = 8'h92;
    localparam logic [7:0] KEY_DN    = 8'h93;
    localparam logic [7:0] KEY_SPACE = 8'h20;
    localparam logic [7:0] KEY_P     = 8'h70;
    localparam logic [7:0] KEY_ESC   = 8'h1B;

    // Bit positions inside key_held = {p2_dn, p2_up, p1_dn, p1_up}
    localparam int KH_P1_UP = 0;
    localparam int KH_P1_DN = 1;
    localparam int KH_P2_UP = 2;
    localparam int KH_P2_DN = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } hs_state_t;

endpackage

// File: rtl/paddle_axis.sv
// One paddle position register: clamped step up/down on tick, recenter override.
module paddle_axis #(
    parameter int POS_W       = 10,
    parameter int PADDLE_MAX  = 400,
    parameter int PADDLE_INIT = 200,
    parameter int PADDLE_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic             recenter,
    input  logic             up,
    input  logic             dn,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W:0]   STEP_X = (POS_W+1)'(PADDLE_STEP);
    localparam logic [POS_W:0]   MAX_X  = (POS_W+1)'(PADDLE_MAX);
    localparam logic [POS_W-1:0] INIT   = POS_W'(PADDLE_INIT);

    logic [POS_W:0]   pos_x;
    logic [POS_W-1:0] pos_next;

    // One spare bit keeps pos + STEP from wrapping before the clamp compare.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pos_x    = {1'b0, pos};
        pos_next = pos;
        if (up && !dn) begin
            pos_next = POS_W'((pos_x < STEP_X) ? '0 : pos_x - STEP_X);
        end else if (dn && !up) begin
            pos_next = POS_W'((pos_x > MAX_X - STEP_X) ? MAX_X : pos_x + STEP_X);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos <= INIT;
        end else if (recenter) begin
            pos <= INIT;
        end else if (tick && enable) begin
            pos <= pos_next;
        end
    end

endmodule

// File: rtl/kbd_paddle_ctrl.sv
// Consumes the decoded PS/2 key stream, tracks held game keys and drives
// two clamped paddle positions plus serve/pause controls.
module kbd_paddle_ctrl #(
    parameter int TICK_DIV    = 250000,
    parameter int POS_W       = 10,
    parameter int PADDLE_MAX  = 400,
    parameter int PADDLE_INIT = 200,
    parameter int PADDLE_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       scancode,
    input  logic             data_ready,
    input  logic             released,
    input  logic             err_ind,
    output logic             read,
    input  logic             enable,
    input  logic             recenter,
    output logic [3:0]       key_held,
    output logic [POS_W-1:0] p1_pos,
    output logic [POS_W-1:0] p2_pos,
    output logic             serve,
    output logic             paused,
    output logic [7:0]       err_cnt
);

    import kbd_codes_pkg::*;

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    hs_state_t        state, state_next;
    logic [7:0]       code_q;
    logic             rel_q;
    logic             err_q;
    logic             space_held;
    logic             pause_held;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // S_WAIT holds off until data_ready drops so one code is never read twice.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (data_ready) state_next = S_ACK;
            S_ACK:   state_next = S_WAIT;
            S_WAIT:  if (!data_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q <= '0;
            rel_q  <= 1'b0;
            err_q  <= 1'b0;
            read   <= 1'b0;
        end else begin
            read <= (state == S_ACK);
            if (state == S_IDLE && data_ready) begin
                code_q <= scancode;
                rel_q  <= released;
                err_q  <= err_ind;
            end
        end
    end

    // Press-edge detection on space and pause suppresses typematic repeats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_held   <= '0;
            space_held <= 1'b0;
            pause_held <= 1'b0;
            serve      <= 1'b0;
            paused     <= 1'b0;
            err_cnt    <= '0;
        end else begin
            serve <= 1'b0;
            if (state == S_ACK) begin
                if (err_q) begin
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end else begin
                    case (code_q)
                        KEY_W:  key_held[KH_P1_UP] <= !rel_q;
                        KEY_S:  key_held[KH_P1_DN] <= !rel_q;
                        KEY_UP: key_held[KH_P2_UP] <= !rel_q;
                        KEY_DN: key_held[KH_P2_DN] <= !rel_q;
                        KEY_SPACE: begin
                            if (!rel_q && !space_held) serve <= 1'b1;
                            space_held <= !rel_q;
                        end
                        KEY_P, KEY_ESC: begin
                            if (!rel_q && !pause_held) paused <= !paused;
                            pause_held <= !rel_q;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + CNT_W'(1);
    end

    paddle_axis #(
        .POS_W       (POS_W),
        .PADDLE_MAX  (PADDLE_MAX),
        .PADDLE_INIT (PADDLE_INIT),
        .PADDLE_STEP (PADDLE_STEP)
    ) u_p1 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .enable   (enable),
        .recenter (recenter),
        .up       (key_held[KH_P1_UP]),
        .dn       (key_held[KH_P1_DN]),
        .pos      (p1_pos)
    );

    paddle_axis #(
        .POS_W       (POS_W),
        .PADDLE_MAX  (PADDLE_MAX),
        .PADDLE_INIT (PADDLE_INIT),
        .PADDLE_STEP (PADDLE_STEP)
    ) u_p2 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .enable   (enable),
        .recenter (recenter),
        .up       (key_held[KH_P2_UP]),
        .dn       (key_held[KH_P2_DN]),
        .pos      (p2_pos)
    );

endmodule

// File: tb/tb_kbd_paddle_ctrl.sv
// Directed bench for kbd_paddle_ctrl; a second instance starts at 398 to reach the clamps.
module tb_kbd_paddle_ctrl;

    import kbd_codes_pkg::*;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] scancode;
    logic       data_ready, released, err_ind, enable, recenter;

    logic       read, serve, paused;
    logic [3:0] key_held;
    logic [9:0] p1_pos, p2_pos;
    logic [7:0] err_cnt;

    logic       e_read, e_serve, e_paused;
    logic [3:0] e_key_held;
    logic [9:0] e_p1_pos, e_p2_pos;
    logic [7:0] e_err_cnt;

    int checks = 0;
    int errors = 0;
    int serve_pulses = 0;
    int serve_cycles = 0;
    logic serve_q = 1'b0;

    always #5 clk = ~clk;

    kbd_paddle_ctrl #(.TICK_DIV(TD)) u_dut (
        .clk(clk), .rst(rst), .scancode(scancode), .data_ready(data_ready),
        .released(released), .err_ind(err_ind), .read(read), .enable(enable),
        .recenter(recenter), .key_held(key_held), .p1_pos(p1_pos), .p2_pos(p2_pos),
        .serve(serve), .paused(paused), .err_cnt(err_cnt)
    );

    kbd_paddle_ctrl #(.TICK_DIV(TD), .PADDLE_INIT(398)) u_edge (
        .clk(clk), .rst(rst), .scancode(scancode), .data_ready(data_ready),
        .released(released), .err_ind(err_ind), .read(e_read), .enable(enable),
        .recenter(recenter), .key_held(e_key_held), .p1_pos(e_p1_pos), .p2_pos(e_p2_pos),
        .serve(e_serve), .paused(e_paused), .err_cnt(e_err_cnt)
    );

    always @(negedge clk) begin
        if (serve) serve_cycles <= serve_cycles + 1;
        if (serve && !serve_q) serve_pulses <= serve_pulses + 1;
        serve_q <= serve;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One full handshake; a missing read within the budget counts as a failure.
    task automatic press(input logic [7:0] code, input logic rel, input logic err);
        logic got;
        got = 1'b0;
        @(negedge clk);
        scancode = code; released = rel; err_ind = err; data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (read) begin
                got = 1'b1;
                break;
            end
        end
        check("ack", got, 1);
        data_ready = 1'b0; err_ind = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Enable for a multiple of TD edges: exactly n ticks whatever the counter phase.
    task automatic run_ticks(input int n);
        @(negedge clk);
        enable = 1'b1;
        repeat (TD * n) @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic pulse_recenter();
        @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
    endtask

    initial begin
        logic [9:0] prev;
        logic       found;
        int         reads;

        rst = 1'b1; scancode = '0; data_ready = 1'b0; released = 1'b0;
        err_ind = 1'b0; enable = 1'b0; recenter = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read", read, 0);
        check("rst_key_held", key_held, 0);
        check("rst_p1", p1_pos, 200);
        check("rst_p2", p2_pos, 200);
        check("rst_serve", serve, 0);
        check("rst_paused", paused, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_edge_p1", e_p1_pos, 398);
        rst = 1'b0;

        // 1: read timing and p1 up movement
        @(negedge clk);
        scancode = KEY_W; released = 1'b0; data_ready = 1'b1;
        @(negedge clk);
        check("read_lat1", read, 0);
        @(negedge clk);
        check("read_lat2", read, 1);
        check("w_held", key_held, 4'b0001);
        @(negedge clk);
        check("read_width", read, 0);
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("frozen_p1", p1_pos, 200);
        run_ticks(1);
        check("p1_tick1", p1_pos, 196);
        run_ticks(1);
        check("p1_tick2", p1_pos, 192);
        check("p2_idle", p2_pos, 200);
        press(KEY_W, 1'b1, 1'b0);
        check("w_release", key_held, 0);
        pulse_recenter();
        check("recenter_p1", p1_pos, 200);
        check("recenter_edge", e_p1_pos, 398);

        // 2: clamps at PADDLE_MAX and 0
        press(KEY_S, 1'b0, 1'b0);
        run_ticks(1);
        check("clamp_max", e_p1_pos, 400);
        run_ticks(2);
        check("stay_max", e_p1_pos, 400);
        check("p1_down3", p1_pos, 212);
        press(KEY_S, 1'b1, 1'b0);
        press(KEY_W, 1'b0, 1'b0);
        pulse_recenter();
        run_ticks(99);
        check("near_min", e_p1_pos, 2);
        run_ticks(1);
        check("clamp_min", e_p1_pos, 0);
        run_ticks(2);
        check("stay_min", e_p1_pos, 0);
        check("p1_min", p1_pos, 0);
        press(KEY_W, 1'b1, 1'b0);
        pulse_recenter();

        // 3: serve with typematic suppression
        press(KEY_SPACE, 1'b0, 1'b0);
        press(KEY_SPACE, 1'b0, 1'b0);
        press(KEY_SPACE, 1'b0, 1'b0);
        press(KEY_SPACE, 1'b1, 1'b0);
        press(KEY_SPACE, 1'b0, 1'b0);
        press(KEY_SPACE, 1'b1, 1'b0);
        check("serve_pulses", serve_pulses, 2);
        check("serve_cycles", serve_cycles, 2);

        // 4: error frames discarded, counter saturates
        press(KEY_W, 1'b0, 1'b1);
        check("err_key_held", key_held, 0);
        check("err_cnt1", err_cnt, 1);
        for (int i = 1; i < 254; i++) press(KEY_W, 1'b0, 1'b1);
        check("err_cnt254", err_cnt, 254);
        for (int i = 254; i < 300; i++) press(KEY_W, 1'b0, 1'b1);
        check("err_cnt_sat", err_cnt, 255);
        check("err_p1", p1_pos, 200);

        // 5: both p2 keys held, then down only, then recenter on a tick
        press(KEY_UP, 1'b0, 1'b0);
        press(KEY_DN, 1'b0, 1'b0);
        check("p2_both_held", key_held, 4'b1100);
        run_ticks(5);
        check("p2_both", p2_pos, 200);
        press(KEY_UP, 1'b1, 1'b0);
        run_ticks(2);
        check("p2_down2", p2_pos, 208);
        @(negedge clk);
        enable = 1'b1;
        prev = p2_pos;
        found = 1'b0;
        for (int i = 0; i < 2 * TD; i++) begin
            @(negedge clk);
            if (p2_pos != prev) begin
                found = 1'b1;
                break;
            end
        end
        check("tick_seen", found, 1);
        check("p2_down3", p2_pos, 212);
        repeat (TD - 1) @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        enable = 1'b0;
        check("recenter_on_tick", p2_pos, 200);
        check("recenter_keeps_keys", key_held, 4'b1000);

        // 6: long data_ready, pause toggling, reset mid-handshake
        @(negedge clk);
        scancode = 8'h41; released = 1'b0; data_ready = 1'b1;
        reads = 0;
        repeat (12) begin
            @(negedge clk);
            if (read) reads++;
        end
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("single_read", reads, 1);
        check("unmapped", key_held, 4'b1000);
        press(KEY_P, 1'b0, 1'b0);
        check("pause_on", paused, 1);
        press(KEY_P, 1'b0, 1'b0);
        check("pause_repeat", paused, 1);
        press(KEY_P, 1'b1, 1'b0);
        press(KEY_ESC, 1'b0, 1'b0);
        check("pause_esc", paused, 0);
        press(KEY_ESC, 1'b1, 1'b0);
        press(KEY_P, 1'b0, 1'b0);
        check("pause_again", paused, 1);

        @(negedge clk);
        scancode = KEY_W; released = 1'b0; data_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("read_before_rst", read, 1);
        rst = 1'b1;
        data_ready = 1'b0;
        #1;
        check("rst_async_read", read, 0);
        check("rst2_key_held", key_held, 0);
        check("rst2_p1", p1_pos, 200);
        check("rst2_p2", p2_pos, 200);
        check("rst2_paused", paused, 0);
        check("rst2_err_cnt", err_cnt, 0);
        check("rst2_serve", serve, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_read", read, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
